// File: rtl/ctrl_8085_multi_pkg.sv
// Shared encodings for the 8085-style multi-cycle control FSM: states, opcode
// classes, opcode values and datapath mux-select codes.
package ctrl_8085_multi_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
`ifdef ILLEGAL_TRAP_EN
    ,
    S_TRAP     = 4'd12
`endif
  } state_t;

  typedef enum logic [3:0] {
    CLS_R   = 4'd0,
    CLS_RL  = 4'd1,
    CLS_I   = 4'd2,
    CLS_CMP = 4'd3,
    CLS_LD  = 4'd4,
    CLS_ST  = 4'd5,
    CLS_JMP = 4'd6,
    CLS_JZ  = 4'd7,
    CLS_HLT = 4'd8,
    CLS_ILL = 4'd15
  } opclass_t;

  localparam logic [4:0] OP_R_LAST   = 5'h03;
  localparam logic [4:0] OP_RL       = 5'h04;
  localparam logic [4:0] OP_I_FIRST  = 5'h05;
  localparam logic [4:0] OP_I_LAST   = 5'h0B;
  localparam logic [4:0] OP_CMP      = 5'h0C;
  localparam logic [4:0] OP_LD       = 5'h0F;
  localparam logic [4:0] OP_ST       = 5'h10;
  localparam logic [4:0] OP_JMP      = 5'h11;
  localparam logic [4:0] OP_JZ       = 5'h12;
  localparam logic [4:0] OP_HLT      = 5'h1F;
  localparam logic [4:0] FN_RL_FIRST = 5'h0A;
  localparam logic [4:0] FN_RL_LAST  = 5'h0C;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_ONE     = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/opclass_8085_multi.sv
// Combinational opcode/funct classifier: maps the instruction fields to a
// class code used by the control FSM, plus a convenience illegal flag.
module opclass_8085_multi
  import ctrl_8085_multi_pkg::*;
#(
  parameter int OPW = 5,
  parameter int FNW = 5
) (
  input  logic [OPW-1:0] opcode_i,
  input  logic [FNW-1:0] funct_i,
  output opclass_t       opclass_o,
  output logic           is_illegal_o
);

  // NOTE: every output gets a default before the if-chain, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    opclass_o = CLS_ILL;
    if (opcode_i <= OPW'(OP_R_LAST)) begin
      opclass_o = CLS_R;
    end else if (opcode_i == OPW'(OP_RL)) begin
      if (funct_i >= FNW'(FN_RL_FIRST) && funct_i <= FNW'(FN_RL_LAST)) begin
        opclass_o = CLS_RL;
      end
    end else if (opcode_i >= OPW'(OP_I_FIRST) && opcode_i <= OPW'(OP_I_LAST)) begin
      opclass_o = CLS_I;
    end else if (opcode_i == OPW'(OP_CMP)) begin
      opclass_o = CLS_CMP;
    end else if (opcode_i == OPW'(OP_LD)) begin
      opclass_o = CLS_LD;
    end else if (opcode_i == OPW'(OP_ST)) begin
      opclass_o = CLS_ST;
    end else if (opcode_i == OPW'(OP_JMP)) begin
      opclass_o = CLS_JMP;
    end else if (opcode_i == OPW'(OP_JZ)) begin
      opclass_o = CLS_JZ;
    end else if (opcode_i == OPW'(OP_HLT)) begin
      opclass_o = CLS_HLT;
    end
    is_illegal_o = (opclass_o == CLS_ILL);
  end

endmodule

// File: rtl/main_control_8085_multi.sv
// Moore main-control FSM for the 8085-style multi-cycle core.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes; otherwise they execute as NOP.
module main_control_8085_multi
  import ctrl_8085_multi_pkg::*;
#(
  parameter int OPW = 5,
  parameter int FNW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           pc_write,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic           ALUop,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic           flag_write,
  output logic [1:0]     pc_source,
  output logic           halted,
  output logic           illegal,
  output logic [3:0]     state
);

  state_t   state_q, state_d;
  opclass_t cls;
  logic     unused_is_illegal;

  opclass_8085_multi #(
    .OPW(OPW),
    .FNW(FNW)
  ) u_opclass (
    .opcode_i    (opcode),
    .funct_i     (funct),
    .opclass_o   (cls),
    .is_illegal_o(unused_is_illegal)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ALUop      = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    flag_write = 1'b0;
    pc_source  = PCSRC_ALU;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUop     = 1'b1;
        alu_src_b = SRCB_ONE;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUop     = 1'b1;
        alu_src_b = SRCB_IMM;
        case (cls)
          CLS_R, CLS_RL:   state_d = S_EXEC_R;
          CLS_I, CLS_CMP:  state_d = S_EXEC_I;
          CLS_LD, CLS_ST:  state_d = S_MEM_ADDR;
          CLS_JMP, CLS_JZ: state_d = S_BRANCH;
          CLS_HLT:         state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          default:         state_d = S_TRAP;
`else
          default:         state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        flag_write = 1'b1;
        state_d    = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        flag_write = 1'b1;
        state_d    = (cls == CLS_CMP) ? S_FETCH : S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ALUop     = 1'b1;
        state_d   = (cls == CLS_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        pc_source = PCSRC_ALUOUT;
        pc_write  = (cls == CLS_JMP) | ((cls == CLS_JZ) & zero);
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: halted = 1'b1;
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal_q <= 1'b0;
    else if (state_d == S_TRAP)  illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_main_control_8085_multi.sv
// Directed self-checking bench for main_control_8085_multi: state sequences,
// per-state control outputs, cycle counts, halt, illegal handling, async reset.
module tb_main_control_8085_multi;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC_R = 4'd3;
  localparam logic [3:0] ST_EXEC_I = 4'd4;
  localparam logic [3:0] ST_MADDR  = 4'd5;
  localparam logic [3:0] ST_MRD    = 4'd6;
  localparam logic [3:0] ST_MWR    = 4'd7;
  localparam logic [3:0] ST_WB_ALU = 4'd8;
  localparam logic [3:0] ST_WB_MEM = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_HALT   = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  typedef struct packed {
    logic       pw, irw, mr, mw, iord, asa;
    logic [1:0] asb;
    logic       aop, rw, m2r, fw;
    logic [1:0] pcs;
    logic       halt, ill;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] opcode, funct;
  logic zero;
  logic pc_write, ir_write, mem_read, mem_write, iord, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic ALUop, reg_write, mem_to_reg, flag_write, halted, illegal;
  logic [3:0] state;
  ctl_t obs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  main_control_8085_multi dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ALUop(ALUop), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .flag_write(flag_write), .pc_source(pc_source),
    .halted(halted), .illegal(illegal), .state(state)
  );

  assign obs = {pc_write, ir_write, mem_read, mem_write, iord, alu_src_a,
                alu_src_b, ALUop, reg_write, mem_to_reg, flag_write,
                pc_source, halted, illegal};

  // Expected control word for a state, written from the state table.
  function automatic ctl_t model(logic [3:0] st, logic z, logic is_jmp);
    ctl_t c = '0;
    case (st)
      ST_FETCH:  begin c.pw = 1; c.irw = 1; c.mr = 1; c.aop = 1; c.asb = 2'b01; end
      ST_DECODE: begin c.aop = 1; c.asb = 2'b10; end
      ST_EXEC_R: begin c.asa = 1; c.asb = 2'b00; c.fw = 1; end
      ST_EXEC_I: begin c.asa = 1; c.asb = 2'b10; c.fw = 1; end
      ST_MADDR:  begin c.asa = 1; c.asb = 2'b10; c.aop = 1; end
      ST_MRD:    begin c.mr = 1; c.iord = 1; end
      ST_MWR:    begin c.mw = 1; c.iord = 1; end
      ST_WB_ALU: c.rw = 1;
      ST_WB_MEM: begin c.rw = 1; c.m2r = 1; end
      ST_BRANCH: begin c.pcs = 2'b01; c.pw = is_jmp ? 1'b1 : z; end
      ST_HALT:   c.halt = 1;
      ST_TRAP:   begin c.halt = 1; c.ill = 1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Reset pulse ending on the negedge where the FSM sits in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== ST_IDLE || obs !== '0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: state=%0d outputs=%h, expected state=%0d outputs=0000",
                 i, state, obs, ST_IDLE);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || obs !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: state=%0d outputs=%h, expected %0d/0000", state, obs, ST_IDLE);
    end
    @(negedge clk);
    checks++;
    if (state !== ST_FETCH || obs !== model(ST_FETCH, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL reset_first_fetch: state=%0d outputs=%h, expected %0d/%h",
               state, obs, ST_FETCH, model(ST_FETCH, 1'b0, 1'b0));
    end
  endtask

  task automatic test_r_type();
    logic [4:0] ops [2] = '{5'h01, 5'h04};
    logic [4:0] fns [2] = '{5'h06, 5'h0B};
    logic [3:0] seq [4] = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_ALU};
    for (int v = 0; v < 2; v++) begin
      opcode = ops[v]; funct = fns[v];
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (state !== seq[i] || obs !== model(seq[i], zero, 1'b0)) begin
          failures++;
          $display("FAIL r_type op=%h cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                   ops[v], i, state, obs, seq[i], model(seq[i], zero, 1'b0));
        end
        @(negedge clk);
      end
      checks++;
      if (state !== ST_FETCH) begin
        failures++;
        $display("FAIL r_type_cpi op=%h: state=%0d after 4 cycles, expected %0d", ops[v], state, ST_FETCH);
      end
    end
  endtask

  task automatic test_i_type();
    logic [4:0] ops [2] = '{5'h07, 5'h0C};
    int         lens [2] = '{4, 3};
    logic [3:0] seq [4] = '{ST_FETCH, ST_DECODE, ST_EXEC_I, ST_WB_ALU};
    for (int v = 0; v < 2; v++) begin
      opcode = ops[v]; funct = 5'h00;
      for (int i = 0; i < lens[v]; i++) begin
        checks++;
        if (state !== seq[i] || obs !== model(seq[i], zero, 1'b0)) begin
          failures++;
          $display("FAIL i_type op=%h cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                   ops[v], i, state, obs, seq[i], model(seq[i], zero, 1'b0));
        end
        @(negedge clk);
      end
      checks++;
      if (state !== ST_FETCH) begin
        failures++;
        $display("FAIL i_type_cpi op=%h: state=%0d after %0d cycles, expected %0d",
                 ops[v], state, lens[v], ST_FETCH);
      end
    end
  endtask

  task automatic test_ld_st();
    logic [4:0] ops [2] = '{5'h0F, 5'h10};
    int         lens [2] = '{5, 4};
    logic [3:0] seq [2][5] = '{'{ST_FETCH, ST_DECODE, ST_MADDR, ST_MRD, ST_WB_MEM},
                               '{ST_FETCH, ST_DECODE, ST_MADDR, ST_MWR, ST_IDLE}};
    for (int v = 0; v < 2; v++) begin
      int writes = 0;
      opcode = ops[v]; funct = 5'h00;
      for (int i = 0; i < lens[v]; i++) begin
        if (mem_write === 1'b1) writes++;
        checks++;
        if (state !== seq[v][i] || obs !== model(seq[v][i], zero, 1'b0)) begin
          failures++;
          $display("FAIL ld_st op=%h cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                   ops[v], i, state, obs, seq[v][i], model(seq[v][i], zero, 1'b0));
        end
        @(negedge clk);
      end
      checks++;
      if (state !== ST_FETCH || writes != v) begin
        failures++;
        $display("FAIL ld_st_cpi op=%h: state=%0d write_strobes=%0d, expected state=%0d write_strobes=%0d",
                 ops[v], state, writes, ST_FETCH, v);
      end
    end
  endtask

  task automatic test_branch();
    logic [4:0] ops [3] = '{5'h11, 5'h12, 5'h12};
    logic       zs  [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] seq [3] = '{ST_FETCH, ST_DECODE, ST_BRANCH};
    for (int v = 0; v < 3; v++) begin
      logic is_jmp = (ops[v] == 5'h11);
      opcode = ops[v]; funct = 5'h00; zero = zs[v];
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (state !== seq[i] || obs !== model(seq[i], zs[v], is_jmp)) begin
          failures++;
          $display("FAIL branch op=%h zero=%0b cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                   ops[v], zs[v], i, state, obs, seq[i], model(seq[i], zs[v], is_jmp));
        end
        @(negedge clk);
      end
      checks++;
      if (state !== ST_FETCH) begin
        failures++;
        $display("FAIL branch_cpi op=%h zero=%0b: state=%0d, expected %0d", ops[v], zs[v], state, ST_FETCH);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [4:0] ops [2] = '{5'h04, 5'h0D};
    logic [4:0] fns [2] = '{5'h01, 5'h0A};
    logic [3:0] seq [2] = '{ST_FETCH, ST_DECODE};
    for (int v = 0; v < 2; v++) begin
      opcode = ops[v]; funct = fns[v];
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (state !== seq[i] || obs !== model(seq[i], zero, 1'b0)) begin
          failures++;
          $display("FAIL illegal op=%h fn=%h cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                   ops[v], fns[v], i, state, obs, seq[i], model(seq[i], zero, 1'b0));
        end
        @(negedge clk);
      end
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (state !== ST_TRAP || obs !== model(ST_TRAP, zero, 1'b0)) begin
          failures++;
          $display("FAIL illegal_trap op=%h cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                   ops[v], i, state, obs, ST_TRAP, model(ST_TRAP, zero, 1'b0));
        end
        @(negedge clk);
      end
      do_reset();
`endif
      checks++;
      if (state !== ST_FETCH || illegal !== 1'b0) begin
        failures++;
        $display("FAIL illegal_return op=%h: state=%0d illegal=%0b, expected state=%0d illegal=0",
                 ops[v], state, illegal, ST_FETCH);
      end
    end
  endtask

  task automatic test_halt();
    opcode = 5'h1F; funct = 5'h00;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (state !== ST_HALT || obs !== model(ST_HALT, zero, 1'b0)) begin
        failures++;
        $display("FAIL halt cycle %0d: state=%0d outputs=%h, expected %0d/%h",
                 i, state, obs, ST_HALT, model(ST_HALT, zero, 1'b0));
      end
      @(negedge clk);
    end
    do_reset();
    checks++;
    if (state !== ST_FETCH || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset_restart: state=%0d halted=%0b, expected state=%0d halted=0",
               state, halted, ST_FETCH);
    end
  endtask

  task automatic test_store_abort();
    opcode = 5'h10; funct = 5'h00;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (state !== ST_MWR || mem_write !== 1'b1) begin
      failures++;
      $display("FAIL abort_reach_mem_wr: state=%0d mem_write=%0b, expected %0d/1", state, mem_write, ST_MWR);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== ST_IDLE || obs !== '0) begin
      failures++;
      $display("FAIL abort_async_reset: state=%0d outputs=%h, expected %0d/0000", state, obs, ST_IDLE);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== ST_IDLE || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart_idle: state=%0d mem_write=%0b, expected %0d/0", state, mem_write, ST_IDLE);
    end
    @(negedge clk);
    checks++;
    if (state !== ST_FETCH || obs !== model(ST_FETCH, zero, 1'b0)) begin
      failures++;
      $display("FAIL abort_restart_fetch: state=%0d outputs=%h, expected %0d/%h",
               state, obs, ST_FETCH, model(ST_FETCH, zero, 1'b0));
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 5'h00; funct = 5'h00; zero = 1'b0;
    test_reset();
    test_r_type();
    test_i_type();
    test_ld_st();
    test_branch();
    test_illegal();
    test_halt();
    test_store_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
